// File: rtl/madgwick_wb_fifo.sv
// Wishbone wrapper for the Madgwick filter core: buffers samples and results, sequences the core.
// Ack one cycle after strobe; sample to result 3 cycles + core latency; full input FIFO drops pushes.

module madgwick_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [W-1:0]             i_push_dat,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head_dat,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];
  assign w_push     = i_push & ~o_full & ~i_flush;
  assign w_pop      = i_pop & ~o_empty & ~i_flush;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end
endmodule

module madgwick_wb_fifo #(
  parameter int SAMPLE_W  = 16,
  parameter int Q_W       = 32,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          adr_i,
  input  logic [31:0]         dat_i,
  output logic [31:0]         dat_o,
  input  logic                we_i,
  input  logic                stb_i,
  input  logic                cyc_i,
  output logic                ack_o,
  output logic                inta_o,
  output logic                core_rst_n_o,
  output logic                core_valid_o,
  input  logic                core_ready_i,
  output logic [SAMPLE_W-1:0] core_a_x_o,
  output logic [SAMPLE_W-1:0] core_a_y_o,
  output logic [SAMPLE_W-1:0] core_a_z_o,
  output logic [SAMPLE_W-1:0] core_w_x_o,
  output logic [SAMPLE_W-1:0] core_w_y_o,
  output logic [SAMPLE_W-1:0] core_w_z_o,
  input  logic                core_valid_i,
  output logic                core_ready_o,
  input  logic [Q_W-1:0]      core_q_w_i,
  input  logic [Q_W-1:0]      core_q_x_i,
  input  logic [Q_W-1:0]      core_q_y_i,
  input  logic [Q_W-1:0]      core_q_z_i
);
  localparam int ICW = $clog2(IN_DEPTH) + 1;
  localparam int OCW = $clog2(OUT_DEPTH) + 1;

  typedef struct packed {
    logic [SAMPLE_W-1:0] a_x, a_y, a_z, w_x, w_y, w_z;
  } sample_t;

  typedef struct packed {
    logic [Q_W-1:0] q_w, q_x, q_y, q_z;
  } quat_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_ack;
  logic [31:0]   r_dat_o;
  logic          r_enable, r_auto, r_int_en, r_start_pend;
  logic [2:0]    r_irq;
  logic          r_ovf, r_unf, r_inta;
  logic [7:0]    r_thresh;
  sample_t       r_stg, r_core_smp;

  logic          w_acc, w_wr, w_rd, w_ctrl_wr, w_flush, w_abort;
  logic          w_in_push, w_in_pop, w_out_push, w_out_pop, w_launch;
  logic          w_in_full, w_in_empty, w_out_full, w_out_empty;
  logic [ICW-1:0] w_in_cnt;
  logic [OCW-1:0] w_out_cnt, w_out_cnt_nxt;
  sample_t       w_push_smp, w_in_head;
  quat_t         w_core_q, w_out_head;
  logic [31:0]   w_rd_dat;
  logic [2:0]    w_irq_set, w_irq_w1c, w_irq_nxt;
  logic          w_thr_hit;
  logic          w_unused;

  assign w_unused  = &{1'b0, dat_i};
  assign w_acc     = cyc_i & stb_i & ~r_ack;
  assign w_wr      = w_acc & we_i;
  assign w_rd      = w_acc & ~we_i;
  assign w_ctrl_wr = w_wr & (adr_i == 6'h00);
  assign w_flush   = w_ctrl_wr & dat_i[4];
  // A write that clears enable or flushes aborts in the same cycle, so no handshake completes then.
  assign w_abort   = ~r_enable | (w_ctrl_wr & (~dat_i[0] | dat_i[4]));
  assign w_in_push = w_wr & (adr_i == 6'h24);
  assign w_out_pop = w_rd & (adr_i == 6'h34);
  assign w_core_q  = {core_q_w_i, core_q_x_i, core_q_y_i, core_q_z_i};

  always_comb begin
    w_push_smp     = r_stg;
    w_push_smp.w_z = dat_i[SAMPLE_W-1:0];
  end

  madgwick_fifo #(.W($bits(sample_t)), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk(clk), .rst_n(rst_n), .i_flush(w_flush), .i_push(w_in_push), .i_push_dat(w_push_smp),
    .i_pop(w_in_pop), .o_head_dat(w_in_head), .o_count(w_in_cnt), .o_full(w_in_full),
    .o_empty(w_in_empty)
  );

  madgwick_fifo #(.W($bits(quat_t)), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk(clk), .rst_n(rst_n), .i_flush(w_flush), .i_push(w_out_push), .i_push_dat(w_core_q),
    .i_pop(w_out_pop), .o_head_dat(w_out_head), .o_count(w_out_cnt), .o_full(w_out_full),
    .o_empty(w_out_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_in_pop    = 1'b0;
    w_out_push  = 1'b0;
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_in_empty && !w_out_full && (r_auto || r_start_pend)) begin
            w_launch    = 1'b1;
            w_state_nxt = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (core_ready_i) begin
            w_in_pop    = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (core_valid_i) begin
            w_out_push  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_out_cnt_nxt = w_out_cnt;
    if (w_flush)
      w_out_cnt_nxt = '0;
    else if ((w_out_push && !w_out_full) && !(w_out_pop && !w_out_empty))
      w_out_cnt_nxt = w_out_cnt + OCW'(1);
    else if (!(w_out_push && !w_out_full) && (w_out_pop && !w_out_empty))
      w_out_cnt_nxt = w_out_cnt - OCW'(1);
  end

  // Threshold fires only on the crossing, aligned with the count update.
  assign w_thr_hit = (r_thresh != 8'd0) && (8'(w_out_cnt_nxt) >= r_thresh) &&
                     (8'(w_out_cnt) < r_thresh);
  assign w_irq_set = {w_thr_hit, w_in_push & w_in_full, w_out_push};
  assign w_irq_w1c = (w_wr && adr_i == 6'h08) ? dat_i[2:0] : 3'b000;
  assign w_irq_nxt = (r_irq & ~w_irq_w1c) | w_irq_set;

  always_comb begin
    w_rd_dat = '0;
    case (adr_i)
      6'h00: w_rd_dat = {29'd0, r_int_en, r_auto, r_enable};
      6'h04: w_rd_dat = {13'd0, r_unf, r_ovf, (r_state != ST_IDLE), 8'(w_out_cnt), 8'(w_in_cnt)};
      6'h08: w_rd_dat = {29'd0, r_irq};
      6'h0C: w_rd_dat = {24'd0, r_thresh};
      6'h10: w_rd_dat = 32'(r_stg.a_x);
      6'h14: w_rd_dat = 32'(r_stg.a_y);
      6'h18: w_rd_dat = 32'(r_stg.a_z);
      6'h1C: w_rd_dat = 32'(r_stg.w_x);
      6'h20: w_rd_dat = 32'(r_stg.w_y);
      6'h24: w_rd_dat = 32'(r_stg.w_z);
      6'h28: w_rd_dat = w_out_empty ? 32'd0 : 32'(w_out_head.q_w);
      6'h2C: w_rd_dat = w_out_empty ? 32'd0 : 32'(w_out_head.q_x);
      6'h30: w_rd_dat = w_out_empty ? 32'd0 : 32'(w_out_head.q_y);
      6'h34: w_rd_dat = w_out_empty ? 32'd0 : 32'(w_out_head.q_z);
      default: w_rd_dat = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack        <= 1'b0;
      r_dat_o      <= '0;
      r_enable     <= 1'b0;
      r_auto       <= 1'b0;
      r_int_en     <= 1'b0;
      r_start_pend <= 1'b0;
      r_irq        <= '0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
      r_inta       <= 1'b0;
      r_thresh     <= '0;
      r_stg        <= '0;
      r_core_smp   <= '0;
    end else begin
      r_ack   <= w_acc;
      r_dat_o <= w_rd ? w_rd_dat : 32'd0;
      if (w_ctrl_wr) begin
        r_enable <= dat_i[0];
        r_auto   <= dat_i[1];
        r_int_en <= dat_i[2];
      end
      if (w_ctrl_wr && dat_i[3])
        r_start_pend <= 1'b1;
      else if (w_launch || !r_enable || (r_state == ST_IDLE && w_in_empty))
        r_start_pend <= 1'b0;
      if (w_wr) begin
        case (adr_i)
          6'h0C: r_thresh  <= dat_i[7:0];
          6'h10: r_stg.a_x <= dat_i[SAMPLE_W-1:0];
          6'h14: r_stg.a_y <= dat_i[SAMPLE_W-1:0];
          6'h18: r_stg.a_z <= dat_i[SAMPLE_W-1:0];
          6'h1C: r_stg.w_x <= dat_i[SAMPLE_W-1:0];
          6'h20: r_stg.w_y <= dat_i[SAMPLE_W-1:0];
          6'h24: r_stg.w_z <= dat_i[SAMPLE_W-1:0];
          default: ;
        endcase
      end
      if (w_launch) r_core_smp <= w_in_head;
      r_irq  <= w_irq_nxt;
      r_inta <= (w_ctrl_wr ? dat_i[2] : r_int_en) & (|w_irq_nxt);
      if (w_in_push && w_in_full)          r_ovf <= 1'b1;
      else if (w_flush || w_irq_w1c[1])    r_ovf <= 1'b0;
      if (w_out_pop && w_out_empty)        r_unf <= 1'b1;
      else if (w_flush)                    r_unf <= 1'b0;
    end
  end

  assign ack_o        = r_ack;
  assign dat_o        = r_dat_o;
  assign inta_o       = r_inta;
  assign core_rst_n_o = r_enable;
  assign core_valid_o = (r_state == ST_ISSUE);
  assign core_ready_o = (r_state == ST_WAIT);
  assign core_a_x_o   = r_core_smp.a_x;
  assign core_a_y_o   = r_core_smp.a_y;
  assign core_a_z_o   = r_core_smp.a_z;
  assign core_w_x_o   = r_core_smp.w_x;
  assign core_w_y_o   = r_core_smp.w_y;
  assign core_w_z_o   = r_core_smp.w_z;
endmodule

// File: tb/tb_madgwick_wb_fifo.sv
// Directed bench for madgwick_wb_fifo with a behavioural filter core of programmable latency.
module tb_madgwick_wb_fifo;
  logic        clk, rst_n;
  logic [5:0]  adr_i;
  logic [31:0] dat_i, dat_o;
  logic        we_i, stb_i, cyc_i, ack_o, inta_o;
  logic        core_rst_n_o, core_valid_o, core_ready_i, core_valid_i, core_ready_o;
  logic [15:0] core_a_x_o, core_a_y_o, core_a_z_o, core_w_x_o, core_w_y_o, core_w_z_o;
  logic [31:0] core_q_w_i, core_q_x_i, core_q_y_i, core_q_z_i;

  int n_vec = 0;
  int n_err = 0;
  int lat   = 5;
  logic [31:0] rd;

  madgwick_wb_fifo dut (
    .clk(clk), .rst_n(rst_n), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .we_i(we_i),
    .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o), .inta_o(inta_o), .core_rst_n_o(core_rst_n_o),
    .core_valid_o(core_valid_o), .core_ready_i(core_ready_i),
    .core_a_x_o(core_a_x_o), .core_a_y_o(core_a_y_o), .core_a_z_o(core_a_z_o),
    .core_w_x_o(core_w_x_o), .core_w_y_o(core_w_y_o), .core_w_z_o(core_w_z_o),
    .core_valid_i(core_valid_i), .core_ready_o(core_ready_o),
    .core_q_w_i(core_q_w_i), .core_q_x_i(core_q_x_i), .core_q_y_i(core_q_y_i),
    .core_q_z_i(core_q_z_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wb_wr(input logic [5:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    adr_i = a; dat_i = d; we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
    @(posedge clk); #1;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wb_rd(input logic [5:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    adr_i = a; we_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1;
    @(posedge clk); #1;
    d = dat_o;
    cyc_i = 1'b0; stb_i = 1'b0;
  endtask

  task automatic push(input logic [15:0] ax);
    wb_wr(6'h10, {16'h0, ax});
    wb_wr(6'h24, 32'h0000_0006);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Core model: result q = (0x40000000, a_x^0x100, 0, w_z^0x6) after lat cycles.
  initial begin
    logic [15:0] cap_ax, cap_wz;
    core_valid_i = 1'b0;
    core_q_w_i = '0; core_q_x_i = '0; core_q_y_i = '0; core_q_z_i = '0;
    forever begin
      @(negedge clk);
      if (core_valid_o && core_ready_i) begin
        cap_ax = core_a_x_o;
        cap_wz = core_w_z_o;
        @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        #1;
        core_valid_i = 1'b1;
        core_q_w_i = 32'h4000_0000;
        core_q_x_i = {16'h0, cap_ax} ^ 32'h100;
        core_q_y_i = 32'h0;
        core_q_z_i = {16'h0, cap_wz} ^ 32'h6;
        for (int t = 0; t < 30; t++) begin
          @(negedge clk);
          if (core_ready_o) break;
        end
        @(posedge clk); #1;
        core_valid_i = 1'b0;
      end
    end
  end

  initial begin
    rst_n = 1'b0; adr_i = '0; dat_i = '0; we_i = 1'b0; stb_i = 1'b0; cyc_i = 1'b0;
    core_ready_i = 1'b1;
    #23;
    chk("rst_inta", {31'd0, inta_o}, 32'd0);
    chk("rst_core_rst_n", {31'd0, core_rst_n_o}, 32'd0);
    chk("rst_core_valid", {31'd0, core_valid_o}, 32'd0);
    chk("rst_ack", {31'd0, ack_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    wb_rd(6'h00, rd); chk("rst_ctrl", rd, 32'h0);
    wb_rd(6'h04, rd); chk("rst_status", rd, 32'h0);

    // Single-shot: stage one sample, then start.
    wb_wr(6'h00, 32'h1);
    chk("core_rst_rise", {31'd0, core_rst_n_o}, 32'd1);
    wb_wr(6'h14, 32'h2); wb_wr(6'h18, 32'h3); wb_wr(6'h1C, 32'h4); wb_wr(6'h20, 32'h5);
    push(16'h0100);
    wb_rd(6'h04, rd); chk("ss_status_in1", rd, 32'h0000_0001);
    wb_rd(6'h10, rd); chk("stg_ax_rb", rd, 32'h0000_0100);
    wb_wr(6'h00, 32'h9);
    cycles(20);
    wb_rd(6'h04, rd); chk("ss_status_out1", rd, 32'h0000_0100);
    wb_rd(6'h08, rd); chk("ss_irq_done", rd, 32'h1);
    wb_rd(6'h00, rd); chk("ss_ctrl_start_rd0", rd, 32'h1);
    chk("ss_inta_masked", {31'd0, inta_o}, 32'd0);
    wb_rd(6'h28, rd); chk("ss_qw", rd, 32'h4000_0000);
    wb_rd(6'h2C, rd); chk("ss_qx", rd, 32'h0);
    wb_rd(6'h34, rd); chk("ss_qz_pop", rd, 32'h0);
    wb_rd(6'h04, rd); chk("ss_status_popped", rd, 32'h0);
    wb_rd(6'h34, rd); chk("unf_read_zero", rd, 32'h0);
    wb_rd(6'h04, rd); chk("unf_sticky", rd, 32'h0004_0000);
    wb_wr(6'h08, 32'h1);
    wb_rd(6'h08, rd); chk("irq_w1c_done", rd, 32'h0);
    wb_wr(6'h0C, 32'h1FF);
    wb_rd(6'h0C, rd); chk("thresh_trunc", rd, 32'hFF);
    wb_wr(6'h0C, 32'h0);
    wb_rd(6'h38, rd); chk("unmapped_rd", rd, 32'h0);

    // Overflow with the core stalled.
    core_ready_i = 1'b0;
    wb_wr(6'h00, 32'h10);
    wb_wr(6'h00, 32'h7);
    wb_rd(6'h04, rd); chk("flush_status", rd, 32'h0);
    for (int k = 1; k <= 4; k++) push(16'h0100 | 16'(k));
    wb_rd(6'h04, rd); chk("ovf_in4_busy", rd, 32'h0001_0004);
    chk("issue_valid", {31'd0, core_valid_o}, 32'd1);
    chk("issue_hold_ax", {16'd0, core_a_x_o}, 32'h0101);
    push(16'h0105);
    chk("ovf_inta", {31'd0, inta_o}, 32'd1);
    wb_rd(6'h04, rd); chk("ovf_status", rd, 32'h0003_0004);
    wb_rd(6'h08, rd); chk("ovf_irq", rd, 32'h2);
    core_ready_i = 1'b1;
    cycles(100);
    wb_rd(6'h04, rd); chk("ovf_out4", rd, 32'h0002_0400);
    wb_rd(6'h08, rd); chk("ovf_irq_done", rd, 32'h3);
    for (int k = 1; k <= 4; k++) begin
      wb_rd(6'h2C, rd); chk($sformatf("ovf_order_%0d", k), rd, 32'(k));
      wb_rd(6'h34, rd);
    end
    wb_rd(6'h04, rd); chk("ovf_drained", rd, 32'h0002_0000);
    wb_wr(6'h08, 32'h7);
    wb_rd(6'h04, rd); chk("ovf_w1c_status", rd, 32'h0);

    // Threshold crossing.
    wb_wr(6'h0C, 32'h2);
    for (int k = 5; k <= 7; k++) push(16'h0100 | 16'(k));
    cycles(80);
    wb_rd(6'h04, rd); chk("thr_status", rd, 32'h0000_0300);
    wb_rd(6'h08, rd); chk("thr_irq", rd, 32'h5);
    chk("thr_inta", {31'd0, inta_o}, 32'd1);
    wb_wr(6'h08, 32'h7);
    chk("thr_inta_drop", {31'd0, inta_o}, 32'd0);
    wb_rd(6'h08, rd); chk("thr_irq_clr", rd, 32'h0);

    // Output FIFO full blocks launch.
    wb_wr(6'h0C, 32'h0);
    push(16'h0108);
    cycles(40);
    push(16'h0109);
    cycles(40);
    wb_rd(6'h04, rd); chk("full_blocks", rd, 32'h0000_0401);
    wb_rd(6'h2C, rd); chk("full_head", rd, 32'h5);
    wb_rd(6'h34, rd);
    cycles(40);
    wb_rd(6'h04, rd); chk("full_relaunch", rd, 32'h0000_0400);
    for (int k = 6; k <= 9; k++) begin
      wb_rd(6'h2C, rd); chk($sformatf("full_order_%0d", k), rd, 32'(k));
      wb_rd(6'h34, rd);
    end
    wb_wr(6'h08, 32'h7);

    // Disable mid-WAIT.
    lat = 15;
    push(16'h010A);
    cycles(2);
    chk("wait_ready", {31'd0, core_ready_o}, 32'd1);
    wb_wr(6'h00, 32'h6);
    chk("dis_core_rst", {31'd0, core_rst_n_o}, 32'd0);
    chk("dis_ready", {31'd0, core_ready_o}, 32'd0);
    cycles(60);
    wb_rd(6'h04, rd); chk("dis_status", rd, 32'h0);
    wb_rd(6'h08, rd); chk("dis_irq", rd, 32'h0);

    // Async reset mid-ISSUE.
    lat = 5;
    core_ready_i = 1'b0;
    wb_wr(6'h00, 32'h3);
    push(16'h010B);
    cycles(3);
    chk("rst_pre_valid", {31'd0, core_valid_o}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, core_valid_o}, 32'd0);
    chk("rst_mid_core_rst", {31'd0, core_rst_n_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    wb_rd(6'h04, rd); chk("rst2_status", rd, 32'h0);
    wb_rd(6'h00, rd); chk("rst2_ctrl", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
